// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions. These are the RX state encodings
//            (Gray-style, matching the TX FSM), the parity-type constants,
//            the default data width and a 2-of-3 majority helper.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Adjacent states in the normal frame order differ in one bit.
  localparam logic [2:0] RX_ST_IDLE   = 3'b000;
  localparam logic [2:0] RX_ST_START  = 3'b001;
  localparam logic [2:0] RX_ST_DATA   = 3'b011;
  localparam logic [2:0] RX_ST_PARITY = 3'b010;
  localparam logic [2:0] RX_ST_STOP   = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = RX_ST_IDLE,
    S_START  = RX_ST_START,
    S_DATA   = RX_ST_DATA,
    S_PARITY = RX_ST_PARITY,
    S_STOP   = RX_ST_STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial line, frame configuration and received-word/strobe
//            bundle of the UART receiver. The master side drives the line
//            and the configuration, and the slave side is the receiver.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) ();

  logic                  rx_in_rx;
  logic [PRESCALE_W-1:0] prescale_rx;
  logic                  par_en_rx;
  logic                  par_typ_rx;
  logic [DATA_WIDTH-1:0] p_data_rx;
  logic                  data_valid_rx;
  logic                  par_err_rx;
  logic                  stp_err_rx;

  modport master (
    output rx_in_rx, prescale_rx, par_en_rx, par_typ_rx,
    input  p_data_rx, data_valid_rx, par_err_rx, stp_err_rx
  );

  modport slave (
    input  rx_in_rx, prescale_rx, par_en_rx, par_typ_rx,
    output p_data_rx, data_valid_rx, par_err_rx, stp_err_rx
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : Per-bit edge counter (0..P-1). It captures the line at
//            ec = P/2-1 and P/2, and latches the 2-of-3 majority at
//            ec = P/2+1. bit_end flags ec = P-1.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  i_rx,
  input  wire logic                  i_count_en,
  input  wire logic [PRESCALE_W-1:0] i_prescale,
  output logic      [PRESCALE_W-1:0] o_ec,
  output logic                       o_sampled_bit,
  output logic                       o_bit_end
);

  logic [PRESCALE_W-1:0] ec_q, ec_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  bit_q, bit_d;

  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;
  logic                  w_bit_end;

  assign w_half    = {1'b0, i_prescale[PRESCALE_W-1:1]};
  assign w_last    = i_prescale - PRESCALE_W'(1);
  assign w_bit_end = (ec_q == w_last);

  // Advance or wrap the edge counter, and capture the three mid-bit samples.
  always_comb begin
    ec_d  = '0;
    s0_d  = s0_q;
    s1_d  = s1_q;
    bit_d = bit_q;
    if (i_count_en) begin
      ec_d = w_bit_end ? '0 : ec_q + PRESCALE_W'(1);
    end
    if (ec_q == w_half - PRESCALE_W'(1)) begin
      s0_d = i_rx;
    end
    if (ec_q == w_half) begin
      s1_d = i_rx;
    end
    if (ec_q == w_half + PRESCALE_W'(1)) begin
      bit_d = maj3(s0_q, s1_q, i_rx);
    end
  end

  // Sampler registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ec_q  <= '0;
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
      bit_q <= 1'b1;
    end else begin
      ec_q  <= ec_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      bit_q <= bit_d;
    end
  end

  assign o_ec          = ec_q;
  assign o_sampled_bit = bit_q;
  assign o_bit_end     = w_bit_end;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver. It handles the start, data (LSB first), optional
//            parity and stop bits. A good frame gives a one-cycle
//            data_valid_rx and loads p_data_rx. A bad frame gives one-cycle
//            par_err_rx and/or stp_err_rx.
//            Define UART_RX_SYNC_EN to add a two-flop input synchronizer.
//            This adds 2 cycles of latency.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int PRESCALE_W = 6
) (
  input  wire logic  clk_rx,
  input  wire logic  rst_rx,
  uart_rx_if.slave   rx_if
);

  localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic w_rx;

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  assign sync1_d = rx_if.rx_in_rx;
  assign sync2_d = sync1_q;

  // Two-flop synchronizer. It resets to the idle line level.
  always_ff @(posedge clk_rx) begin
    if (!rst_rx) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign w_rx = sync2_q;
`else
  assign w_rx = rx_if.rx_in_rx;
`endif

  rx_state_e             state_q, state_d;
  logic [BC_W-1:0]       bc_q, bc_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_flag_q, par_flag_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;

  logic [PRESCALE_W-1:0] w_ec;
  logic                  w_sampled_bit;
  logic                  w_bit_end;
  logic                  w_count_en;

  // In IDLE the counter runs only on the detection cycle. Otherwise it free-runs.
  assign w_count_en = (state_q != S_IDLE) || !w_rx;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .clk           (clk_rx),
    .rst_n         (rst_rx),
    .i_rx          (w_rx),
    .i_count_en    (w_count_en),
    .i_prescale    (rx_if.prescale_rx),
    .o_ec          (w_ec),
    .o_sampled_bit (w_sampled_bit),
    .o_bit_end     (w_bit_end)
  );

  // Frame FSM next state, data shifting, parity check and output strobes.
  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    shift_d    = shift_q;
    par_flag_d = par_flag_q;
    par_typ_d  = par_typ_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    serr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        bc_d       = '0;
        par_flag_d = 1'b0;
        // The falling line is the ec = 0 cycle of the start bit.
        if (!w_rx && (w_ec == '0)) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = w_sampled_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          shift_d = {w_sampled_bit, shift_q[DATA_WIDTH-1:1]};
          if (bc_q == BC_W'(DATA_WIDTH - 1)) begin
            bc_d      = '0;
            par_typ_d = rx_if.par_typ_rx;
            state_d   = rx_if.par_en_rx ? S_PARITY : S_STOP;
          end else begin
            bc_d = bc_q + BC_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          par_flag_d = w_sampled_bit ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          state_d = S_IDLE;
          serr_d  = !w_sampled_bit;
          perr_d  = par_flag_q;
          if (w_sampled_bit && !par_flag_q) begin
            valid_d  = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All receiver state and registered outputs.
  always_ff @(posedge clk_rx) begin
    if (!rst_rx) begin
      state_q    <= S_IDLE;
      bc_q       <= '0;
      shift_q    <= '0;
      par_flag_q <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      shift_q    <= shift_d;
      par_flag_q <= par_flag_d;
      par_typ_q  <= par_typ_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign rx_if.p_data_rx     = p_data_q;
  assign rx_if.data_valid_rx = valid_q;
  assign rx_if.par_err_rx    = perr_q;
  assign rx_if.stp_err_rx    = serr_q;

endmodule
`default_nettype wire
